// File: rtl/hbbus_pkg.sv
// Shared hexbus definitions used by the receive-side interrupt stripper
// and the transmit-side interrupt inserter.
package hbbus_pkg;

  localparam int HB_WORDW = 34;
  localparam logic [4:0] INT_PREFIX = 5'b11010;
  localparam logic [HB_WORDW-1:0] INT_WORD = {INT_PREFIX, 29'b0};

  // Full-width compare; a word that only shares the prefix is ordinary data.
  function automatic logic is_int_word(input logic [HB_WORDW-1:0] word);
    return word == INT_WORD;
  endfunction

endpackage

// File: rtl/hbskid.sv
// Generic two-entry registered skid buffer. The output register feeds
// downstream; the skid register catches one word while downstream stalls.
// Upstream stall is taken straight from the skid valid flop.
module hbskid #(
  parameter int W = 34
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_busy,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_busy
);

  logic         r_out_valid;
  logic [W-1:0] r_out_data;
  logic         r_skid_valid;
  logic [W-1:0] r_skid_data;
  logic         w_accept;
  logic         w_out_free;

  assign w_accept   = i_valid && !r_skid_valid;
  assign w_out_free = !r_out_valid || !i_busy;

  // Output and skid registers: skid has priority into the output slot so
  // words leave in arrival order.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= i_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
    end
  end

  assign o_busy  = r_skid_valid;
  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;

endmodule

// File: rtl/hbdeints.sv
// Hexbus interrupt stripper: interrupt words are removed from the stream
// and turned into a pulse, sticky pending/overrun flags and a saturating
// count; every other word passes through a two-entry skid buffer.
module hbdeints
  import hbbus_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_stb,
  input  logic [HB_WORDW-1:0] i_word,
  output logic                o_busy,
  output logic                o_stb,
  output logic [HB_WORDW-1:0] o_word,
  input  logic                i_busy,
  output logic                o_interrupt,
  output logic                o_int_pending,
  input  logic                i_int_ack,
  output logic                o_overrun,
  output logic [CW-1:0]       o_int_count
);

  logic          w_is_int;
  logic          w_skid_busy;
  logic          w_int_accept;
  logic          r_interrupt;
  logic          r_pending;
  logic          r_overrun;
  logic [CW-1:0] r_count;

  assign w_is_int     = is_int_word(i_word);
  assign w_int_accept = i_stb && !w_skid_busy && w_is_int;

  hbskid #(.W(HB_WORDW)) u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_stb && !w_is_int),
    .i_data    (i_word),
    .o_busy    (w_skid_busy),
    .o_valid   (o_stb),
    .o_data    (o_word),
    .i_busy    (i_busy)
  );

  // Interrupt pulse, sticky flags and saturating event counter; a new
  // interrupt in the same cycle as an ack leaves pending set, overrun clear.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_interrupt <= 1'b0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_count     <= '0;
    end else begin
      r_interrupt <= w_int_accept;
      if (w_int_accept) begin
        r_pending <= 1'b1;
        r_overrun <= i_int_ack ? 1'b0 : (r_overrun || r_pending);
        if (r_count != '1) begin
          r_count <= r_count + 1'b1;
        end
      end else if (i_int_ack) begin
        r_pending <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_busy        = w_skid_busy;
  assign o_interrupt   = r_interrupt;
  assign o_int_pending = r_pending;
  assign o_overrun     = r_overrun;
  assign o_int_count   = r_count;

endmodule

// File: tb/tb_hbdeints.sv
// Bench for hbdeints: a queue-based model of the data path plus a flag
// model, compared every cycle, with directed phases and a random phase.
module tb_hbdeints;
  import hbbus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_stb = 1'b0;
  logic [33:0] i_word = '0;
  logic        i_busy = 1'b0;
  logic        i_ack = 1'b0;

  logic        o_busy, o_stb, o_int, o_pend, o_ovr;
  logic [33:0] o_word;
  logic [7:0]  o_cnt;
  logic        s_busy, s_stb, s_int, s_pend, s_ovr;
  logic [33:0] s_word;
  logic [1:0]  s_cnt;

  hbdeints #(.CW(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_stb(i_stb), .i_word(i_word),
    .o_busy(o_busy), .o_stb(o_stb), .o_word(o_word), .i_busy(i_busy),
    .o_interrupt(o_int), .o_int_pending(o_pend), .i_int_ack(i_ack),
    .o_overrun(o_ovr), .o_int_count(o_cnt)
  );

  hbdeints #(.CW(2)) dut_sat (
    .i_clk(clk), .i_reset_n(rst_n), .i_stb(i_stb), .i_word(i_word),
    .o_busy(s_busy), .o_stb(s_stb), .o_word(s_word), .i_busy(i_busy),
    .o_interrupt(s_int), .o_int_pending(s_pend), .i_int_ack(i_ack),
    .o_overrun(s_ovr), .o_int_count(s_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: words held by the block, in arrival order.
  logic [33:0] q[$];
  bit m_int, m_pend, m_ovr;
  int m_cnt, m_cnt2;
  bit chk_en = 0;

  // Model update on each rising edge from the inputs driven at the last negedge.
  always @(posedge clk) begin
    bit acc, is_int;
    chk_en = 1;
    if (!rst_n) begin
      q.delete();
      m_int = 0; m_pend = 0; m_ovr = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      acc    = i_stb && (q.size() < 2);
      is_int = acc && (i_word == INT_WORD);
      if (q.size() > 0 && !i_busy) void'(q.pop_front());
      if (acc && !is_int) q.push_back(i_word);
      m_int = is_int;
      if (is_int) begin
        m_ovr  = i_ack ? 0 : (m_ovr || m_pend);
        m_pend = 1;
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end else if (i_ack) begin
        m_pend = 0;
        m_ovr  = 0;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("o_stb", o_stb, q.size() > 0);
      if (q.size() > 0) chk("o_word", o_word, q[0]);
      chk("o_busy", o_busy, q.size() == 2);
      chk("o_interrupt", o_int, m_int);
      chk("o_int_pending", o_pend, m_pend);
      chk("o_overrun", o_ovr, m_ovr);
      chk("o_int_count", o_cnt, m_cnt);
      chk("sat_count", s_cnt, m_cnt2);
      chk("sat_stb", s_stb, q.size() > 0);
      if (q.size() > 0) chk("sat_word", s_word, q[0]);
    end
  end

  // Drive at a negedge, let one rising edge pass, return at the next negedge.
  task automatic step(input bit stb, input logic [33:0] w, input bit busy, input bit ack);
    i_stb = stb; i_word = w; i_busy = busy; i_ack = ack;
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [33:0] A = 34'h0_1234_5678;
  localparam logic [33:0] B = 34'h2_0000_0ABC;
  localparam logic [33:0] C = 34'h3_FFFF_0001;

  initial begin
    logic [33:0] w;
    @(negedge clk);
    // Reset held with a word presented.
    rst_n = 0;
    for (int i = 0; i < 3; i++) step(1, 34'h5, 0, 0);
    chk("rst_stb", o_stb, 0);
    chk("rst_word", o_word, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_flags", {o_int, o_pend, o_ovr}, 0);
    chk("rst_cnt", o_cnt, 0);
    rst_n = 1;
    step(1, 34'h5, 0, 0);
    chk("first_word", {o_stb, o_word}, {1'b1, 34'h5});
    step(0, 0, 0, 0);
    chk("first_drained", o_stb, 0);

    // Streaming.
    for (int i = 1; i <= 8; i++) begin
      step(1, 34'(i), 0, 0);
      chk("stream_word", o_word, 34'(i));
      chk("stream_busy", o_busy, 0);
    end
    step(0, 0, 0, 0);

    // Interrupt removal.
    step(1, A, 0, 0);
    chk("intA_word", o_word, A);
    step(1, INT_WORD, 0, 0);
    chk("int_pulse", o_int, 1);
    chk("int_cnt1", o_cnt, 1);
    chk("int_pend1", o_pend, 1);
    step(1, B, 0, 0);
    chk("intB_word", {o_stb, o_word}, {1'b1, B});
    chk("int_pulse_end", o_int, 0);
    step(0, 0, 0, 0);

    // Backpressure.
    step(1, A, 1, 0);
    step(1, B, 1, 0);
    chk("bp_busy", o_busy, 1);
    chk("bp_holdA", o_word, A);
    step(1, C, 1, 0);
    chk("bp_stillA", o_word, A);
    step(1, C, 0, 0);
    chk("bp_B", {o_stb, o_word, o_busy}, {1'b1, B, 1'b0});
    step(1, C, 0, 0);
    chk("bp_C", o_word, C);
    step(0, 0, 0, 0);
    chk("bp_empty", o_stb, 0);

    // Overrun and acknowledge.
    step(0, 0, 0, 1);
    chk("ack_clear", o_pend, 0);
    step(1, INT_WORD, 0, 0);
    step(1, INT_WORD, 0, 0);
    chk("ovr_set", {o_pend, o_ovr}, 2'b11);
    chk("ovr_cnt", o_cnt, 3);
    step(0, 0, 0, 1);
    chk("ovr_ack", {o_pend, o_ovr}, 2'b00);
    step(1, INT_WORD, 0, 1);
    chk("ack_new_wins", {o_pend, o_ovr}, 2'b10);
    chk("ack_cnt", o_cnt, 4);
    step(1, INT_WORD, 0, 0);
    chk("cnt5", o_cnt, 5);
    chk("sat_cnt3", s_cnt, 3);
    step(0, 0, 0, 0);

    // Random phase; upstream holds its word while the model says busy.
    for (int n = 0; n < 3000; n++) begin
      bit nrst, nbusy, nack;
      nrst  = ($urandom_range(0, 399) != 0);
      nbusy = ($urandom_range(0, 2) == 0);
      nack  = ($urandom_range(0, 9) == 0);
      if (!(i_stb && q.size() == 2 && rst_n)) begin
        if ($urandom_range(0, 3) == 0) w = INT_WORD;
        else w = {2'($urandom), $urandom};
        i_stb  = ($urandom_range(0, 3) != 0);
        i_word = w;
      end
      rst_n = nrst;
      step(i_stb, i_word, nbusy, nack);
    end
    rst_n = 1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
